// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and flag bit positions for the iterative ALU.
// The state set depends on ITER_ALU_DIV_EN (divider states exist only when defined).
package alu_pkg;

    localparam logic [4:0] OP_ADD0 = 5'b00011;
    localparam logic [4:0] OP_ADD1 = 5'b01100;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND0 = 5'b01010;
    localparam logic [4:0] OP_AND1 = 5'b01101;
    localparam logic [4:0] OP_OR0  = 5'b01011;
    localparam logic [4:0] OP_OR1  = 5'b01110;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    localparam int FLAG_OVF   = 3;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_DBZ   = 0;

`ifdef ITER_ALU_DIV_EN
    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DFIX} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_MUL} state_t;
`endif

    function automatic logic [3:0] pack_flags(input logic ovf, input logic carry,
                                              input logic zero, input logic dbz);
        logic [3:0] f;
        f             = 4'b0000;
        f[FLAG_OVF]   = ovf;
        f[FLAG_CARRY] = carry;
        f[FLAG_ZERO]  = zero;
        f[FLAG_DBZ]   = dbz;
        return f;
    endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Request/result bundle of the iterative ALU; master issues operations, slave is the ALU.
interface iter_alu_if #(parameter int WIDTH = 32);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Zlowout;
    logic [WIDTH-1:0] Zhighout;
    logic [3:0]       flags;

    modport master (output start, op, A, B,
                    input  busy, done, Zlowout, Zhighout, flags);
    modport slave  (input  start, op, A, B,
                    output busy, done, Zlowout, Zhighout, flags);
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider on operand magnitudes, one quotient bit per cycle.
// done is high during the sign-fix cycle, when quotient/remainder are valid.
module seq_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);
    typedef enum logic [1:0] {DV_IDLE, DV_RUN, DV_FIX} dv_state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    dv_state_t        phase_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] q_r, rem_r, dvs_r, a_r;
    logic             sa_r, sb_r, dbz_r, ovf_r;
    logic [WIDTH:0]   shifted_s, diff_s;
    logic             ge_s;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? (~v + ONE) : v;
    endfunction

    // A negative trial difference (its MSB) means the divisor did not fit: restore.
    assign shifted_s = {rem_r, q_r[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, dvs_r};
    assign ge_s      = ~diff_s[WIDTH];

    // Sign fix: quotient truncates toward zero, remainder follows the dividend.
    always_comb begin
        done      = (phase_r == DV_FIX);
        dbz       = dbz_r;
        ovf       = ovf_r;
        if (dbz_r) begin
            quotient  = '1;
            remainder = a_r;
        end else begin
            quotient  = (sa_r ^ sb_r) ? (~q_r + ONE) : q_r;
            remainder = sa_r ? (~rem_r + ONE) : rem_r;
        end
    end

    // Operand capture, iteration and phase sequencing.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            phase_r <= DV_IDLE;
            count_r <= '0;
            q_r     <= '0;
            rem_r   <= '0;
            dvs_r   <= '0;
            a_r     <= '0;
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            dbz_r   <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            case (phase_r)
                DV_IDLE: begin
                    if (start) begin
                        phase_r <= DV_RUN;
                        count_r <= '0;
                        q_r     <= mag(dividend);
                        rem_r   <= '0;
                        dvs_r   <= mag(divisor);
                        a_r     <= dividend;
                        sa_r    <= dividend[WIDTH-1];
                        sb_r    <= divisor[WIDTH-1];
                        dbz_r   <= (divisor == '0);
                        ovf_r   <= (dividend == MIN_VAL) && (divisor == '1);
                    end
                end
                DV_RUN: begin
                    q_r   <= {q_r[WIDTH-2:0], ge_s};
                    rem_r <= ge_s ? diff_s[WIDTH-1:0] : shifted_s[WIDTH-1:0];
                    if (count_r == LAST_CNT) begin
                        phase_r <= DV_FIX;
                        count_r <= '0;
                    end else begin
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DV_FIX:  phase_r <= DV_IDLE;
                default: phase_r <= DV_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/iter_alu.sv
// Iterative ALU: single-cycle logic/arith/shift ops, Booth multiply, optional divider.
// Define ITER_ALU_DIV_EN to build the divider; otherwise op 10000 is flagged illegal (ovf).
module iter_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic       clock,
    input  logic       clear,
    iter_alu_if.slave  bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W:0]   W_CNT    = (CNT_W + 1)'(WIDTH);

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             busy_r, done_r;
    logic [WIDTH-1:0] zlo_r, zhi_r;
    logic [3:0]       flags_r;

    logic [WIDTH:0]   acc_r;
    logic [WIDTH-1:0] mq_r, mcand_r;
    logic             qm1_r;
    logic [WIDTH:0]   booth_sum_s, acc_nx_s;
    logic [WIDTH-1:0] mq_nx_s;

    logic [CNT_W-1:0] amt_s;
    logic [CNT_W:0]   inv_amt_s;
    logic [WIDTH-1:0] sra_s, ror_s, rol_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_lo_s;
    logic             ovf_s, carry_s;

    function automatic logic is_zero(input logic [2*WIDTH-1:0] v);
        return (v == '0);
    endfunction

    assign amt_s     = bus.B[CNT_W-1:0];
    assign inv_amt_s = W_CNT - {1'b0, amt_s};
    assign sra_s     = $signed(bus.A) >>> amt_s;
    assign ror_s     = (bus.A >> amt_s) | (bus.A << inv_amt_s);
    assign rol_s     = (bus.A << amt_s) | (bus.A >> inv_amt_s);

    // Single-cycle result and flags from the operands presented on the accepting edge.
    always_comb begin
        sum_s    = '0;
        res_lo_s = '0;
        ovf_s    = 1'b0;
        carry_s  = 1'b0;
        case (bus.op)
            OP_ADD0, OP_ADD1: begin
                sum_s    = {1'b0, bus.A} + {1'b0, bus.B};
                res_lo_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_SUB: begin
                sum_s    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
                res_lo_s = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sum_s[WIDTH-1] != bus.A[WIDTH-1]);
            end
            OP_AND0, OP_AND1: res_lo_s = bus.A & bus.B;
            OP_OR0, OP_OR1:   res_lo_s = bus.A | bus.B;
            OP_SHR:           res_lo_s = bus.A >> amt_s;
            OP_SHRA:          res_lo_s = sra_s;
            OP_SHL:           res_lo_s = bus.A << amt_s;
            OP_ROR:           res_lo_s = ror_s;
            OP_ROL:           res_lo_s = rol_s;
            OP_NEG:           res_lo_s = {WIDTH{1'b0}} - bus.A;
            OP_NOT:           res_lo_s = ~bus.A;
`ifndef ITER_ALU_DIV_EN
            OP_DIV:           ovf_s    = 1'b1;
`endif
            default:          res_lo_s = '0;
        endcase
    end

    // Radix-2 Booth step; the accumulator carries one guard bit so -2^(W-1) operands cannot overflow.
    always_comb begin
        case ({mq_r[0], qm1_r})
            2'b01:   booth_sum_s = acc_r + {mcand_r[WIDTH-1], mcand_r};
            2'b10:   booth_sum_s = acc_r - {mcand_r[WIDTH-1], mcand_r};
            default: booth_sum_s = acc_r;
        endcase
        acc_nx_s = {booth_sum_s[WIDTH], booth_sum_s[WIDTH:1]};
        mq_nx_s  = {booth_sum_s[0], mq_r[WIDTH-1:1]};
    end

`ifdef ITER_ALU_DIV_EN
    logic             div_start_s, div_done_s, div_dbz_s, div_ovf_s;
    logic [WIDTH-1:0] div_q_s, div_r_s;

    assign div_start_s = (state_r == ST_IDLE) && !busy_r && bus.start && (bus.op == OP_DIV);

    seq_divider #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
        .clock     (clock),
        .clear     (clear),
        .start     (div_start_s),
        .dividend  (bus.A),
        .divisor   (bus.B),
        .done      (div_done_s),
        .quotient  (div_q_s),
        .remainder (div_r_s),
        .dbz       (div_dbz_s),
        .ovf       (div_ovf_s)
    );
`endif

    // Control FSM with registered result, flags, busy and done.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_r <= ST_IDLE;
            count_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            zlo_r   <= '0;
            zhi_r   <= '0;
            flags_r <= 4'b0000;
            acc_r   <= '0;
            mq_r    <= '0;
            mcand_r <= '0;
            qm1_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // busy stays high through the done cycle, so acceptance waits one more edge.
                    if (busy_r) begin
                        busy_r <= 1'b0;
                    end else if (bus.start) begin
                        if (bus.op == OP_MUL) begin
                            state_r <= ST_MUL;
                            busy_r  <= 1'b1;
                            count_r <= '0;
                            acc_r   <= '0;
                            mq_r    <= bus.B;
                            mcand_r <= bus.A;
                            qm1_r   <= 1'b0;
`ifdef ITER_ALU_DIV_EN
                        end else if (bus.op == OP_DIV) begin
                            state_r <= ST_DIV;
                            busy_r  <= 1'b1;
                            count_r <= '0;
`endif
                        end else begin
                            zlo_r   <= res_lo_s;
                            zhi_r   <= '0;
                            flags_r <= pack_flags(ovf_s, carry_s, is_zero({{WIDTH{1'b0}}, res_lo_s}), 1'b0);
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_r <= acc_nx_s;
                    mq_r  <= mq_nx_s;
                    qm1_r <= mq_r[0];
                    if (count_r == LAST_CNT) begin
                        state_r <= ST_IDLE;
                        count_r <= '0;
                        zlo_r   <= mq_nx_s;
                        zhi_r   <= acc_nx_s[WIDTH-1:0];
                        flags_r <= pack_flags(1'b0, 1'b0, is_zero({acc_nx_s[WIDTH-1:0], mq_nx_s}), 1'b0);
                        done_r  <= 1'b1;
                    end else begin
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
`ifdef ITER_ALU_DIV_EN
                ST_DIV: begin
                    if (count_r == LAST_CNT) begin
                        state_r <= ST_DFIX;
                        count_r <= '0;
                    end else begin
                        count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DFIX: begin
                    state_r <= ST_IDLE;
                    zlo_r   <= div_q_s;
                    zhi_r   <= div_r_s;
                    flags_r <= pack_flags(div_ovf_s, 1'b0, is_zero({div_r_s, div_q_s}), div_dbz_s);
                    done_r  <= div_done_s;
                end
`endif
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.Zlowout  = zlo_r;
    assign bus.Zhighout = zhi_r;
    assign bus.flags    = flags_r;
endmodule

// File: tb/tb_iter_alu.sv
// Directed self-checking bench for iter_alu at WIDTH=32 (div tests follow ITER_ALU_DIV_EN).
module tb_iter_alu;
    import alu_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;

    iter_alu_if #(.WIDTH(32)) bus ();

    iter_alu #(.WIDTH(32)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Issue one op once the ALU is idle; returns cycles from the accepting edge to done.
    // Operands are scrambled right after acceptance; poke re-raises start mid-operation.
    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int poke, output int lat);
        int guard;
        guard = 0;
        @(negedge clock);
        while (bus.busy && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
        @(posedge clock); #1;
        bus.start = 1'b0; bus.A = ~a; bus.B = ~b;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (lat == poke) begin bus.start = 1'b1; bus.op = OP_ADD0; end
            @(posedge clock); #1;
            bus.start = 1'b0;
            lat++;
        end
    endtask

    task automatic test_reset();
        #1;
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
        tests_run++; if ({bus.Zhighout, bus.Zlowout} !== 64'h0) begin tests_failed++; $display("FAIL reset_z: got %h want 0", {bus.Zhighout, bus.Zlowout}); end
        tests_run++; if (bus.flags !== 4'b0000) begin tests_failed++; $display("FAIL reset_flags: got %b want 0000", bus.flags); end
        @(negedge clock); clear = 1'b1;
    endtask

    task automatic test_add_sub();
        int lat;
        run_op(OP_ADD0, 32'h7FFF_FFFF, 32'h0000_0001, -1, lat);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL add_latency: got %0d want 1", lat); end
        tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL add_busy: got %b want 0", bus.busy); end
        tests_run++; if (bus.Zlowout !== 32'h8000_0000) begin tests_failed++; $display("FAIL add_lo: got %h want 80000000", bus.Zlowout); end
        tests_run++; if (bus.Zhighout !== 32'h0) begin tests_failed++; $display("FAIL add_hi: got %h want 0", bus.Zhighout); end
        tests_run++; if (bus.flags !== 4'b1000) begin tests_failed++; $display("FAIL add_flags: got %b want 1000", bus.flags); end
        run_op(OP_SUB, 32'd5, 32'd5, -1, lat);
        tests_run++; if ({bus.Zlowout, bus.flags} !== {32'h0, 4'b0110}) begin tests_failed++; $display("FAIL sub_equal: got %h/%b want 0/0110", bus.Zlowout, bus.flags); end
        run_op(OP_SUB, 32'd3, 32'd5, -1, lat);
        tests_run++; if ({bus.Zlowout, bus.flags} !== {32'hFFFF_FFFE, 4'b0000}) begin tests_failed++; $display("FAIL sub_borrow: got %h/%b want fffffffe/0000", bus.Zlowout, bus.flags); end
        run_op(OP_ADD1, 32'hFFFF_FFFF, 32'd2, -1, lat);
        tests_run++; if ({bus.Zlowout, bus.flags} !== {32'h1, 4'b0100}) begin tests_failed++; $display("FAIL add_carry: got %h/%b want 1/0100", bus.Zlowout, bus.flags); end
    endtask

    task automatic test_logic();
        int lat;
        run_op(OP_AND1, 32'h0000_F0F0, 32'h0000_FF00, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h0000_F000) begin tests_failed++; $display("FAIL and: got %h want 0000f000", bus.Zlowout); end
        run_op(OP_OR0, 32'h0000_000F, 32'h0000_00F0, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h0000_00FF) begin tests_failed++; $display("FAIL or: got %h want 000000ff", bus.Zlowout); end
        run_op(OP_NOT, 32'h0, 32'h0, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'hFFFF_FFFF) begin tests_failed++; $display("FAIL not: got %h want ffffffff", bus.Zlowout); end
        run_op(OP_NEG, 32'h1, 32'h0, -1, lat);
        tests_run++; if ({bus.Zlowout, bus.flags} !== {32'hFFFF_FFFF, 4'b0000}) begin tests_failed++; $display("FAIL neg: got %h/%b want ffffffff/0000", bus.Zlowout, bus.flags); end
        run_op(5'b00000, 32'h1234, 32'h5678, -1, lat);
        tests_run++; if ({lat, bus.Zlowout, bus.flags} !== {32'd1, 32'h0, 4'b0010}) begin tests_failed++; $display("FAIL undef_op: got lat %0d %h/%b want lat 1 0/0010", lat, bus.Zlowout, bus.flags); end
    endtask

    task automatic test_shift();
        int lat;
        run_op(OP_SHRA, 32'h8000_0000, 32'h0000_0024, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'hF800_0000) begin tests_failed++; $display("FAIL shra: got %h want f8000000", bus.Zlowout); end
        run_op(OP_ROR, 32'h1, 32'h1, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h8000_0000) begin tests_failed++; $display("FAIL ror: got %h want 80000000", bus.Zlowout); end
        run_op(OP_SHR, 32'h8000_0000, 32'h4, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h0800_0000) begin tests_failed++; $display("FAIL shr: got %h want 08000000", bus.Zlowout); end
        run_op(OP_SHL, 32'h1, 32'h1F, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h8000_0000) begin tests_failed++; $display("FAIL shl: got %h want 80000000", bus.Zlowout); end
        run_op(OP_ROL, 32'h8000_0001, 32'h1, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'h0000_0003) begin tests_failed++; $display("FAIL rol: got %h want 00000003", bus.Zlowout); end
        run_op(OP_ROR, 32'hA5A5_0001, 32'h20, -1, lat);
        tests_run++; if (bus.Zlowout !== 32'hA5A5_0001) begin tests_failed++; $display("FAIL ror_zero_amt: got %h want a5a50001", bus.Zlowout); end
    endtask

    task automatic test_mul();
        int lat;
        run_op(OP_MUL, 32'hFFFF_FFFD, 32'd7, 10, lat);
        tests_run++; if (lat !== 33) begin tests_failed++; $display("FAIL mul_latency: got %0d want 33", lat); end
        tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("FAIL mul_busy_at_done: got %b want 1", bus.busy); end
        tests_run++; if ({bus.Zhighout, bus.Zlowout} !== 64'hFFFF_FFFF_FFFF_FFEB) begin tests_failed++; $display("FAIL mul_neg: got %h want ffffffffffffffeb", {bus.Zhighout, bus.Zlowout}); end
        @(posedge clock); #1;
        tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL mul_done_pulse: got %b want 0", bus.done); end
        repeat (4) @(posedge clock); #1;
        tests_run++; if ({bus.Zlowout, bus.done} !== {32'hFFFF_FFEB, 1'b0}) begin tests_failed++; $display("FAIL mul_hold: got %h/%b want ffffffeb/0", bus.Zlowout, bus.done); end
        run_op(OP_MUL, 32'h8000_0000, 32'h8000_0000, -1, lat);
        tests_run++; if ({bus.Zhighout, bus.Zlowout} !== 64'h4000_0000_0000_0000) begin tests_failed++; $display("FAIL mul_min: got %h want 4000000000000000", {bus.Zhighout, bus.Zlowout}); end
        run_op(OP_MUL, 32'h0, 32'd5, -1, lat);
        tests_run++; if ({bus.Zlowout, bus.flags} !== {32'h0, 4'b0010}) begin tests_failed++; $display("FAIL mul_zero: got %h/%b want 0/0010", bus.Zlowout, bus.flags); end
    endtask

    task automatic test_clear_mid_op();
        int lat;
        int seen;
        run_op(OP_ADD0, 32'd9, 32'd1, -1, lat);
        @(negedge clock);
        bus.start = 1'b1; bus.op = OP_MUL; bus.A = 32'd123; bus.B = 32'd456;
        @(posedge clock); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clock);
        #1 clear = 1'b0;
        #1;
        tests_run++; if ({bus.busy, bus.done} !== 2'b00) begin tests_failed++; $display("FAIL clear_ctrl: got %b want 00", {bus.busy, bus.done}); end
        tests_run++; if ({bus.Zhighout, bus.Zlowout, bus.flags} !== 68'h0) begin tests_failed++; $display("FAIL clear_outputs: got %h want 0", {bus.Zhighout, bus.Zlowout, bus.flags}); end
        @(negedge clock); clear = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1) seen++;
        end
        tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL clear_no_done: got %0d done pulses want 0", seen); end
        run_op(OP_ADD0, 32'd2, 32'd3, -1, lat);
        tests_run++; if ({lat, bus.Zlowout} !== {32'd1, 32'd5}) begin tests_failed++; $display("FAIL clear_then_add: got lat %0d %h want lat 1 5", lat, bus.Zlowout); end
    endtask

`ifdef ITER_ALU_DIV_EN
    task automatic test_div();
        int lat;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, -1, lat);
        tests_run++; if (lat !== 34) begin tests_failed++; $display("FAIL div_latency: got %0d want 34", lat); end
        tests_run++; if ({bus.Zhighout, bus.Zlowout, bus.flags} !== {32'hFFFF_FFFF, 32'hFFFF_FFFD, 4'b0000}) begin tests_failed++; $display("FAIL div_signed: got %h %h %b want ffffffff fffffffd 0000", bus.Zhighout, bus.Zlowout, bus.flags); end
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, -1, lat);
        tests_run++; if ({lat, bus.Zhighout, bus.Zlowout, bus.flags} !== {32'd34, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 4'b0001}) begin tests_failed++; $display("FAIL div_by_zero: got lat %0d %h %h %b want lat 34 fffffff9 ffffffff 0001", lat, bus.Zhighout, bus.Zlowout, bus.flags); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, lat);
        tests_run++; if ({bus.Zhighout, bus.Zlowout, bus.flags} !== {32'h0, 32'h8000_0000, 4'b1000}) begin tests_failed++; $display("FAIL div_ovf: got %h %h %b want 0 80000000 1000", bus.Zhighout, bus.Zlowout, bus.flags); end
    endtask
`else
    task automatic test_div_disabled();
        int lat;
        run_op(OP_DIV, 32'd9, 32'd3, -1, lat);
        tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL div_off_latency: got %0d want 1", lat); end
        tests_run++; if ({bus.Zhighout, bus.Zlowout, bus.flags} !== {32'h0, 32'h0, 4'b1010}) begin tests_failed++; $display("FAIL div_off_result: got %h %h %b want 0 0 1010", bus.Zhighout, bus.Zlowout, bus.flags); end
    endtask
`endif

    initial begin
        bus.start = 1'b0; bus.op = 5'b00000; bus.A = 32'h0; bus.B = 32'h0;
        test_reset();
        test_add_sub();
        test_logic();
        test_shift();
        test_mul();
        test_clear_mid_op();
`ifdef ITER_ALU_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/iter_alu.md
ITER_ALU -- requirements
Module: iter_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width; legal values are even and 8..64.
REQ-002 SHALL have parameter CNT_W, default $clog2(WIDTH), shift-amount and iteration-counter width.
REQ-003 SHALL have port clock, input, 1, the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port clear, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1, the operation request, sampled while busy=0.
REQ-006 SHALL have port op, input, 5, opcode: add 00011/01100, sub 00100, and 01010/01101, or 01011/01110, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, mul 01111, div 10000, neg 10001, not 10010.
REQ-007 SHALL have ports A and B, input, WIDTH each, operands captured on accepted start.
REQ-008 SHALL have port busy, output, 1, high while an operation is in flight.
REQ-009 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have ports Zlowout and Zhighout, output, WIDTH each, registered result, low and high halves.
REQ-011 SHALL have port flags, output, 4, {ovf, carry, zero, dbz}, registered with the result.

Function
REQ-012 SHALL use FSM states IDLE, MUL, DIV, DFIX: IDLE->MUL on start&mul; IDLE->DIV on start&div; DIV->DFIX at count=WIDTH-1; MUL->IDLE at count=WIDTH-1; DFIX->IDLE.
REQ-013 SHALL accept start only in IDLE; start while busy=1 is ignored with no side effect.
REQ-014 SHALL latch A, B and op on the accepting edge; later operand changes do not affect the result.
REQ-015 SHALL give done latency from the accepting edge of 1 cycle for single-cycle ops, WIDTH+1 for mul, and WIDTH+2 for div.
REQ-016 SHALL assert busy from the cycle after acceptance until the cycle done is high, inclusive; single-cycle ops never raise busy.
REQ-017 SHALL hold Zlowout, Zhighout and flags stable between done pulses.
REQ-018 SHALL compute add/sub mod 2^WIDTH into Zlowout with Zhighout=0; carry = carry-out (sub: no-borrow); ovf = two's-complement signed overflow.
REQ-019 SHALL use B[CNT_W-1:0] only as the shift/rotate amount; shr zero-fills, shra sign-fills, and amount 0 passes A through.
REQ-020 SHALL compute mul as a signed radix-2 Booth operation, one iteration per cycle, result {Zhighout,Zlowout} = A*B as a 2*WIDTH signed product.
REQ-021 SHALL compute div as signed restoring division on magnitudes with sign fix in DFIX: Zlowout=quotient truncated toward zero, Zhighout=remainder with the sign of A.
REQ-022 SHALL treat div by B=0 as: quotient all ones, remainder=A, dbz=1, same latency.
REQ-023 SHALL treat div of -2^(WIDTH-1) by -1 as: quotient=-2^(WIDTH-1), remainder=0, ovf=1.
REQ-024 SHALL set zero=1 when the full 2*WIDTH result is 0; carry, ovf and dbz are 0 unless defined for the op.
REQ-025 SHALL treat an undefined opcode as a single-cycle op giving result 0, zero=1, and done pulsed.

Reset
REQ-026 SHALL, on clear=0 at any time including mid-operation, go to IDLE and clear busy, done, Zlowout, Zhighout, flags and the counter to 0 immediately, with no done for the aborted op.
REQ-027 SHALL accept start on the first rising edge after clear deasserts.

Configuration
REQ-028 SHALL use macro ITER_ALU_DIV_EN: when defined, div is implemented per REQ-021..023.
REQ-029 SHALL, without ITER_ALU_DIV_EN, remove the divider hardware and the DIV/DFIX states, and treat op 10000 per REQ-025 with ovf=1 as the illegal-op indicator.

Structure
REQ-030 SHALL place opcode localparams, the FSM state encoding and flag bit indices in shared package alu_pkg.
REQ-031 SHALL implement the divider iteration plus sign fix as sub-module seq_divider (start/done handshake, WIDTH parameter), instantiated under ITER_ALU_DIV_EN.

Verification
REQ-032 SHALL cover: WIDTH=32, add A=0x7FFFFFFF B=1 -> done after 1 cycle, Zlowout=0x80000000, ovf=1, carry=0.
REQ-033 SHALL cover: mul A=-3 B=7 -> done after 33 cycles, {Zhigh,Zlow}=0xFFFFFFFF_FFFFFFEB; start pulsed mid-op is ignored.
REQ-034 SHALL cover: div A=-7 B=2 -> done after 34 cycles, Zlowout=-3, Zhighout=-1; then B=0 -> Zlowout=0xFFFFFFFF, Zhighout=A, dbz=1.
REQ-035 SHALL cover: shra A=0x80000000 B=0x24 (amount 4) -> Zlowout=0xF8000000; ror A=1 B=1 -> 0x80000000.
REQ-036 SHALL cover: clear asserted at iteration 10 of mul -> outputs 0 at once and no done; a following add 2+3 gives 5.
REQ-037 SHALL cover: build without ITER_ALU_DIV_EN, op 10000 -> done after 1 cycle, result 0, ovf=1.
